i2c_slave: RTL and testbench

//  Oversampled I2C target; the receiving end for i2c_master on the same SCL/SDA pair.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_slave_if.sv | 24 ++
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_slave.sv | 187 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: address/byte widths and the target-side state encoding.
// Also imported by i2c_master.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ACK_ADDR  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_ACK_WRITE = 3'd4,
        ST_READ      = 3'd5,
        ST_ACK_READ  = 3'd6
    } slave_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Pad-side and user-side signals of the I2C target, bundled with directional modports.
interface i2c_slave_if;
    import i2c_pkg::*;

    logic                  i2c_scl;
    logic                  i2c_sda_in;
    logic                  i2c_sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_req;
    logic                  busy;

    modport slave (
        input  i2c_scl, i2c_sda_in, tx_data,
        output i2c_sda_oe, rx_data, rx_valid, tx_req, busy
    );

    modport master (
        output i2c_scl, i2c_sda_in, tx_data,
        input  i2c_sda_oe, rx_data, rx_valid, tx_req, busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers plus edge, START and STOP detection on the synchronised lines.
// Chains preset to 1 so an idle bus produces no spurious events out of reset.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic s_scl,
    output logic s_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign s_scl     = scl_sync[SYNC_STAGES-1];
    assign s_sda     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = s_scl & ~scl_d;
    assign scl_fall  = ~s_scl & scl_d;
    // SDA may only move with SCL high at START/STOP, so qualify on both SCL samples
    assign start_det = s_scl & scl_d & sda_d & ~s_sda;
    assign stop_det  = s_scl & scl_d & ~sda_d & s_sda;

endmodule

// File: rtl/i2c_slave.sv
// Oversampled I2C target: address match, write-byte delivery and read-byte shifting.
// SDA is driven open-drain through i2c_sda_oe; the pad level supplies the tristate.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    i2c_slave_if.slave bus
);

    logic s_scl, s_sda, scl_rise, scl_fall, start_det, stop_det;

    slave_state_t          state, state_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [I2C_BYTE_W-1:0] shifter, shifter_n;
    logic [I2C_BYTE_W-1:0] rx_data, rx_data_n;
    logic                  rw, rw_n;
    logic                  nack, nack_n;
    logic                  sda_oe, sda_oe_n;
    logic                  rx_valid, rx_valid_n;
    logic                  tx_req, tx_req_n;
    logic                  busy, busy_n;
    logic                  load_tx;
    logic                  sample_bit;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (bus.i2c_scl),
        .sda       (bus.i2c_sda_in),
        .s_scl     (s_scl),
        .s_sda     (s_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sample_bit = scl_rise & s_scl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shifter  <= '0;
            rx_data  <= '0;
            rw       <= 1'b0;
            nack     <= 1'b1;
            sda_oe   <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shifter  <= shifter_n;
            rx_data  <= rx_data_n;
            rw       <= rw_n;
            nack     <= nack_n;
            sda_oe   <= sda_oe_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shifter_n  = shifter;
        rx_data_n  = rx_data;
        rw_n       = rw;
        nack_n     = nack;
        sda_oe_n   = sda_oe;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy;
        load_tx    = 1'b0;

        // Bus conditions override any bit-level activity in the same cycle
        if (stop_det) begin
            state_n   = ST_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = 4'd0;
        end else if (start_det) begin
            state_n   = ST_ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (sample_bit && bit_cnt < 4'd8) begin
                        shifter_n = {shifter[I2C_BYTE_W-2:0], s_sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shifter[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                            state_n  = ST_ACK_ADDR;
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                            rw_n     = shifter[0];
                        end else begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!rw) begin
                            state_n   = ST_WRITE;
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                        end else begin
                            load_tx = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sample_bit && bit_cnt < 4'd8) begin
                        shifter_n = {shifter[I2C_BYTE_W-2:0], s_sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_n  = {shifter[I2C_BYTE_W-2:0], s_sda};
                            rx_valid_n = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n  = ST_ACK_WRITE;
                        sda_oe_n = 1'b1;
                    end
                end
                ST_ACK_WRITE: begin
                    if (scl_fall) begin
                        state_n   = ST_WRITE;
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                    end
                end
                ST_READ: begin
                    // bit_cnt counts bits already placed on SDA; MSB sits in shifter[7]
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n  = ST_ACK_READ;
                            sda_oe_n = 1'b0;
                        end else begin
                            sda_oe_n  = ~shifter[I2C_BYTE_W-2];
                            shifter_n = {shifter[I2C_BYTE_W-2:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_ACK_READ: begin
                    if (sample_bit) begin
                        nack_n = s_sda;
                    end else if (scl_fall) begin
                        if (!nack) begin
                            load_tx = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (load_tx) begin
                state_n   = ST_READ;
                tx_req_n  = 1'b1;
                shifter_n = bus.tx_data;
                sda_oe_n  = ~bus.tx_data[I2C_BYTE_W-1];
                bit_cnt_n = 4'd1;
            end
        end
    end

    assign bus.i2c_sda_oe = sda_oe;
    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.tx_req     = tx_req;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench acting as I2C controller for i2c_slave; a transaction-level model predicts ACKs,
// read bits, delivered bytes and busy, and one compare process checks them every cycle.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_bus;

    always #5 clk = ~clk;

    i2c_slave_if bus();

    assign sda_bus        = m_sda & ~bus.i2c_sda_oe;
    assign bus.i2c_scl    = m_scl;
    assign bus.i2c_sda_in = sda_bus;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int rx_seen = 0;
    int tx_seen = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic win = 1'b0;
    logic exp_oe = 1'b0;
    logic exp_busy = 1'b0;
    logic m_active = 1'b0;
    logic bus_held = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failEvent(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not predicted by the model at %0t", name, $time);
    endtask

    // Single compare process: delivered bytes, read-byte requests, and SDA/busy during SCL high
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            if (bus.rx_valid) begin
                rx_seen++;
                if (exp_rx.size() == 0) failEvent("rx_valid");
                else checkOutput("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
            end
            if (bus.tx_req) begin
                tx_seen++;
                if (tx_q.size() == 0) failEvent("tx_req");
                else void'(tx_q.pop_front());
            end
            if (win) begin
                checkOutput("sda_oe", 32'(bus.i2c_sda_oe), 32'(exp_oe));
                checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
            end
        end
        bus.tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic drive, input logic expect_oe, output logic sampled);
        m_sda = drive;
        waitClk(Q);
        m_scl = 1'b1;
        waitClk(Q);
        exp_oe = expect_oe;
        win = 1'b1;
        waitClk(Q - 1);
        sampled = sda_bus;
        win = 1'b0;
        waitClk(1);
        m_scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic busStart();
        if (bus_held) begin
            m_sda = 1'b1;
            waitClk(Q);
            m_scl = 1'b1;
            waitClk(Q);
        end
        m_sda = 1'b0;
        waitClk(Q);
        m_scl = 1'b0;
        waitClk(Q);
        bus_held = 1'b1;
    endtask

    task automatic busStop();
        m_sda = 1'b0;
        waitClk(Q);
        m_scl = 1'b1;
        waitClk(Q);
        m_sda = 1'b1;
        waitClk(2 * Q);
        bus_held = 1'b0;
        m_active = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic sendAddress(input logic [6:0] addr, input logic rd);
        logic [7:0] b;
        logic s;
        b = {addr, rd};
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], 1'b0, s);
        m_active = (addr == 7'h50);
        exp_busy = m_active;
        applyStimulus(1'b1, m_active, s);
        checkOutput("addr_ack", 32'(s), 32'(!m_active));
    endtask

    task automatic writeByte(input logic [7:0] b);
        logic s;
        if (m_active) exp_rx.push_back(b);
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], 1'b0, s);
        applyStimulus(1'b1, m_active, s);
        checkOutput("data_ack", 32'(s), 32'(!m_active));
    endtask

    task automatic writePartial(input logic [7:0] b, input int nbits);
        logic s;
        for (int i = 7; i > 7 - nbits; i--) applyStimulus(b[i], 1'b0, s);
    endtask

    task automatic readByte(input logic [7:0] b, input logic nack, output logic [7:0] got);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(1'b1, m_active & ~b[i], got[i]);
        if (m_active) checkOutput("read_byte", 32'(got), 32'(b));
        applyStimulus(nack, 1'b0, s);
        if (nack) begin
            m_active = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_oe"}, 32'(bus.i2c_sda_oe), 32'd0);
        checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, "_rxq"}, 32'(exp_rx.size()), 32'd0);
        checkOutput({name, "_txq"}, 32'(tx_q.size()), 32'd0);
    endtask

    initial begin
        #900us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r0;
        int t0;
        logic s;
        logic [7:0] g1;
        logic [7:0] g2;
        logic [7:0] bytes[3];
        logic [6:0] a;
        logic rd;
        int n;

        reset = 1'b1;
        waitClk(3);
        checkOutput("reset_oe", 32'(bus.i2c_sda_oe), 32'd0);
        checkOutput("reset_rx_data", 32'(bus.rx_data), 32'd0);
        checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        checkOutput("reset_tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        waitClk(5);

        $display("[TB] write 0xA0 0xAA");
        r0 = rx_seen;
        busStart();
        sendAddress(7'h50, 1'b0);
        writeByte(8'hAA);
        checkOutput("t1_busy_active", 32'(bus.busy), 32'd1);
        busStop();
        checkIdle("t1");
        checkOutput("t1_rx_data", 32'(bus.rx_data), 32'hAA);
        checkOutput("t1_rx_count", 32'(rx_seen - r0), 32'd1);

        $display("[TB] foreign address 0x51");
        r0 = rx_seen;
        busStart();
        sendAddress(7'h51, 1'b0);
        writeByte(8'h5A);
        writeByte(8'hC3);
        busStop();
        checkIdle("t2");
        checkOutput("t2_rx_count", 32'(rx_seen - r0), 32'd0);
        checkOutput("t2_rx_data", 32'(bus.rx_data), 32'hAA);

        $display("[TB] read 0x3C with NACK");
        t0 = tx_seen;
        tx_q.push_back(8'h3C);
        busStart();
        sendAddress(7'h50, 1'b1);
        readByte(8'h3C, 1'b1, g1);
        checkOutput("t3_byte", 32'(g1), 32'h3C);
        busStop();
        checkIdle("t3");
        checkOutput("t3_tx_count", 32'(tx_seen - t0), 32'd1);

        $display("[TB] read 0x12 ACK, 0x34 NACK");
        t0 = tx_seen;
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        busStart();
        sendAddress(7'h50, 1'b1);
        readByte(8'h12, 1'b0, g1);
        readByte(8'h34, 1'b1, g2);
        checkOutput("t4_byte0", 32'(g1), 32'h12);
        checkOutput("t4_byte1", 32'(g2), 32'h34);
        busStop();
        checkIdle("t4");
        checkOutput("t4_tx_count", 32'(tx_seen - t0), 32'd2);

        $display("[TB] write 0x55, repeated START, read");
        busStart();
        sendAddress(7'h50, 1'b0);
        writeByte(8'h55);
        tx_q.push_back(8'h9E);
        busStart();
        checkOutput("t5_rx_data", 32'(bus.rx_data), 32'h55);
        checkOutput("t5_busy_held", 32'(bus.busy), 32'd1);
        sendAddress(7'h50, 1'b1);
        readByte(8'h9E, 1'b1, g1);
        busStop();
        checkIdle("t5");

        $display("[TB] reset during write ACK");
        busStart();
        sendAddress(7'h50, 1'b0);
        exp_rx.push_back(8'h66);
        for (int i = 7; i >= 0; i--) applyStimulus(g1[0] ^ g1[0] ^ ((8'h66 >> i) & 8'h01) != 0, 1'b0, s);
        m_sda = 1'b1;
        waitClk(Q);
        m_scl = 1'b1;
        waitClk(Q);
        checkOutput("t6_oe_ack", 32'(bus.i2c_sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6_oe_async", 32'(bus.i2c_sda_oe), 32'd0);
        checkOutput("t6_busy_async", 32'(bus.busy), 32'd0);
        waitClk(2);
        reset = 1'b0;
        m_active = 1'b0;
        exp_busy = 1'b0;
        waitClk(Q);
        m_scl = 1'b0;
        waitClk(Q);
        r0 = rx_seen;
        writePartial(8'hF0, 4);
        busStop();
        checkIdle("t6a");
        checkOutput("t6a_rx_count", 32'(rx_seen - r0), 32'd0);

        $display("[TB] STOP after 4 data bits");
        r0 = rx_seen;
        busStart();
        sendAddress(7'h50, 1'b0);
        writeByte(8'h21);
        writePartial(8'hB4, 4);
        busStop();
        checkIdle("t6b");
        checkOutput("t6b_rx_count", 32'(rx_seen - r0), 32'd1);
        checkOutput("t6b_rx_data", 32'(bus.rx_data), 32'h21);
        busStart();
        sendAddress(7'h50, 1'b0);
        writeByte(8'h99);
        busStop();
        checkIdle("t6c");
        checkOutput("t6c_rx_data", 32'(bus.rx_data), 32'h99);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            a = 7'h50;
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h50) a = 7'h51;
            end
            rd = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom_range(0, 255));
            if (rd && a == 7'h50) begin
                for (int k = 0; k < n; k++) tx_q.push_back(bytes[k]);
            end
            busStart();
            sendAddress(a, rd);
            if (rd) begin
                for (int k = 0; k < n; k++) readByte(bytes[k], k == n - 1, g1);
            end else begin
                for (int k = 0; k < n; k++) writeByte(bytes[k]);
                if ($urandom_range(0, 4) == 0) writePartial(8'($urandom_range(0, 255)), $urandom_range(1, 7));
            end
            if ($urandom_range(0, 3) != 0) begin
                busStop();
                checkIdle("rand");
            end
        end
        if (bus_held) begin
            busStop();
            checkIdle("rand_end");
        end

        waitClk(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
